// File: rtl/tree_space_arbiter_pkg.sv
// Shared state encodings and index helpers for the tree space arbiter.
package tree_space_arbiter_pkg;

   localparam logic [1:0] A_IDLE  = 2'd0;
   localparam logic [1:0] A_ISSUE = 2'd1;
   localparam logic [1:0] A_RESP  = 2'd2;

   localparam logic [0:0] F_IDLE  = 1'b0;
   localparam logic [0:0] F_FWD   = 1'b1;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/tree_space_arbiter_rr.sv
// Round-robin arbiter: priority starts at the pointer, pointer moves past the winner.
// Latency: grant is combinational from req; pointer updates on the clock when advance is set.
// Backpressure: none; the pointer only moves when advance is asserted and a request exists.
module rr_arbiter
   import tree_space_arbiter_pkg::*;
#(
   parameter int NB_REQ = 4,
   parameter int IDX_W  = $clog2(NB_REQ)
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              swrst,
   input  logic [NB_REQ-1:0] req,
   input  logic              advance,
   output logic [NB_REQ-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              gnt_vld
);

   logic [IDX_W-1:0] ptr;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      gnt_vld   = 1'b0;
      for (int k = 0; k < NB_REQ; k++) begin
         if (!gnt_vld && req[(int'(ptr) + k) % NB_REQ]) begin
            gnt_vld   = 1'b1;
            grant[(int'(ptr) + k) % NB_REQ] = 1'b1;
            grant_idx = IDX_W'((int'(ptr) + k) % NB_REQ);
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ptr <= '0;
      end else if (swrst) begin
         ptr <= '0;
      end else if (advance && gnt_vld) begin
         ptr <= IDX_W'(wrap_inc(int'(grant_idx), NB_REQ));
      end
   end

endmodule

// File: rtl/tree_space_arbiter.sv
// Shares one tree_space_manager between NB_REQ engines on separate ALLOC and FREE channels.
// Latency: alloc valid->ready 2 cycles min (+1 per manager stall); free accepted same cycle.
// Backpressure: manager ready stalls ISSUE/FWD; a pending root free blocks new alloc requests.
module tree_space_arbiter
   import tree_space_arbiter_pkg::*;
#(
   parameter int NB_REQ         = 4,
   parameter int RAM_ADDR_WIDTH = 16
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic                             swrst,
   input  logic [NB_REQ-1:0]                alloc_valid,
   output logic [NB_REQ-1:0]                alloc_ready,
   output logic [RAM_ADDR_WIDTH-1:0]        alloc_addr,
   input  logic [NB_REQ-1:0]                free_valid,
   input  logic [NB_REQ-1:0]                free_is_root,
   input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0] free_addr,
   output logic [NB_REQ-1:0]                free_ready,
   output logic                             tree_mgt_req_valid,
   input  logic                             tree_mgt_req_ready,
   input  logic [RAM_ADDR_WIDTH-1:0]        tree_mgt_req_addr,
   output logic                             tree_mgt_free_valid,
   output logic                             tree_mgt_free_is_root,
   input  logic                             tree_mgt_free_ready,
   output logic [RAM_ADDR_WIDTH-1:0]        tree_mgt_free_addr,
   output logic                             alloc_busy,
   output logic                             free_busy
);

   localparam int IW = $clog2(NB_REQ);

   logic [1:0]                a_state;
   logic [0:0]                f_state;
   logic [IW-1:0]             gnt_a;
   logic [NB_REQ-1:0]         gnt_a_oh;
   logic [RAM_ADDR_WIDTH-1:0] a_addr_q;
   logic [RAM_ADDR_WIDTH-1:0] f_addr_q;
   logic                      f_root_q;

   logic [NB_REQ-1:0]         a_gnt_oh, f_gnt_oh;
   logic [IW-1:0]             a_gnt_idx, f_gnt_idx;
   logic                      a_gnt_vld, f_gnt_vld;
   logic                      a_adv, f_adv, root_blk;

   assign a_adv = (a_state == A_IDLE) && !swrst;
   assign f_adv = (f_state == F_IDLE) && !swrst;

   rr_arbiter #(.NB_REQ(NB_REQ), .IDX_W(IW)) u_rr_alloc (
      .aclk      (aclk),
      .areset    (areset),
      .swrst     (swrst),
      .req       (alloc_valid),
      .advance   (a_adv),
      .grant     (a_gnt_oh),
      .grant_idx (a_gnt_idx),
      .gnt_vld   (a_gnt_vld)
   );

   rr_arbiter #(.NB_REQ(NB_REQ), .IDX_W(IW)) u_rr_free (
      .aclk      (aclk),
      .areset    (areset),
      .swrst     (swrst),
      .req       (free_valid),
      .advance   (f_adv),
      .grant     (f_gnt_oh),
      .grant_idx (f_gnt_idx),
      .gnt_vld   (f_gnt_vld)
   );

   // A root free must reach the manager before any alloc so the base address is reissued.
   assign root_blk = (f_state == F_FWD) && f_root_q;

   assign tree_mgt_req_valid    = (a_state == A_ISSUE) && alloc_valid[gnt_a] && !root_blk && !swrst;
   assign tree_mgt_free_valid   = (f_state == F_FWD) && !swrst;
   assign tree_mgt_free_addr    = f_addr_q;
   assign tree_mgt_free_is_root = f_root_q;

   assign alloc_ready = ((a_state == A_RESP) && !swrst) ? gnt_a_oh : '0;
   assign alloc_addr  = a_addr_q;
   assign free_ready  = ((f_state == F_IDLE) && !swrst) ? f_gnt_oh : '0;

   assign alloc_busy  = (a_state != A_IDLE);
   assign free_busy   = (f_state != F_IDLE);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         a_state  <= A_IDLE;
         gnt_a    <= '0;
         gnt_a_oh <= '0;
         a_addr_q <= '0;
      end else if (swrst) begin
         a_state  <= A_IDLE;
         gnt_a    <= '0;
         gnt_a_oh <= '0;
         a_addr_q <= '0;
      end else begin
         case (a_state)
            A_IDLE: if (a_gnt_vld) begin
               gnt_a    <= a_gnt_idx;
               gnt_a_oh <= a_gnt_oh;
               a_state  <= A_ISSUE;
            end
            A_ISSUE: if (!alloc_valid[gnt_a]) begin
               a_state <= A_IDLE;
            end else if (tree_mgt_req_valid && tree_mgt_req_ready) begin
               a_addr_q <= tree_mgt_req_addr;
               a_state  <= A_RESP;
            end
            default: a_state <= A_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         f_state  <= F_IDLE;
         f_addr_q <= '0;
         f_root_q <= 1'b0;
      end else if (swrst) begin
         f_state  <= F_IDLE;
         f_addr_q <= '0;
         f_root_q <= 1'b0;
      end else if (f_state == F_IDLE) begin
         if (f_gnt_vld) begin
            f_addr_q <= free_addr[f_gnt_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            f_root_q <= free_is_root[f_gnt_idx];
            f_state  <= F_FWD;
         end
      end else if (tree_mgt_free_ready) begin
         f_state <= F_IDLE;
      end
   end

endmodule

// File: tb/tb_tree_space_arbiter.sv
// Directed bench for tree_space_arbiter: cycle table plus exhaustion and soft-reset sequences.
module tb_tree_space_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           aclk = 1'b0;
   logic           areset, swrst;
   logic [N-1:0]   alloc_valid, alloc_ready, free_valid, free_is_root, free_ready;
   logic [W-1:0]   alloc_addr, tree_mgt_req_addr, tree_mgt_free_addr;
   logic [N*W-1:0] free_addr;
   logic           tree_mgt_req_valid, tree_mgt_req_ready;
   logic           tree_mgt_free_valid, tree_mgt_free_is_root, tree_mgt_free_ready;
   logic           alloc_busy, free_busy;

   tree_space_arbiter #(.NB_REQ(N), .RAM_ADDR_WIDTH(W)) dut (
      .aclk                  (aclk),
      .areset                (areset),
      .swrst                 (swrst),
      .alloc_valid           (alloc_valid),
      .alloc_ready           (alloc_ready),
      .alloc_addr            (alloc_addr),
      .free_valid            (free_valid),
      .free_is_root          (free_is_root),
      .free_addr             (free_addr),
      .free_ready            (free_ready),
      .tree_mgt_req_valid    (tree_mgt_req_valid),
      .tree_mgt_req_ready    (tree_mgt_req_ready),
      .tree_mgt_req_addr     (tree_mgt_req_addr),
      .tree_mgt_free_valid   (tree_mgt_free_valid),
      .tree_mgt_free_is_root (tree_mgt_free_is_root),
      .tree_mgt_free_ready   (tree_mgt_free_ready),
      .tree_mgt_free_addr    (tree_mgt_free_addr),
      .alloc_busy            (alloc_busy),
      .free_busy             (free_busy)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic        sw;
      logic [3:0]  av, fv, fr;
      logic        rr;
      logic [15:0] ra;
      logic        frr;
      logic [3:0]  e_ar;
      logic [15:0] e_aa;
      logic        e_rv;
      logic [3:0]  e_fr;
      logic        e_fv;
      logic [15:0] e_fa;
      logic        e_rt, e_ab, e_fb;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic sw, input logic [3:0] av, input logic [3:0] fv,
                               input logic [3:0] fr, input logic rr, input logic [15:0] ra,
                               input logic frr, input logic [3:0] e_ar, input logic [15:0] e_aa,
                               input logic e_rv, input logic [3:0] e_fr, input logic e_fv,
                               input logic [15:0] e_fa, input logic e_rt, input logic e_ab,
                               input logic e_fb);
      vec_t v;
      v.sw = sw; v.av = av; v.fv = fv; v.fr = fr; v.rr = rr; v.ra = ra; v.frr = frr;
      v.e_ar = e_ar; v.e_aa = e_aa; v.e_rv = e_rv; v.e_fr = e_fr; v.e_fv = e_fv;
      v.e_fa = e_fa; v.e_rt = e_rt; v.e_ab = e_ab; v.e_fb = e_fb;
      return v;
   endfunction

   function automatic logic [44:0] outs();
      return {alloc_ready, alloc_addr, tree_mgt_req_valid, free_ready, tree_mgt_free_valid,
              tree_mgt_free_addr, tree_mgt_free_is_root, alloc_busy, free_busy};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sw, input logic [3:0] av, input logic [3:0] fv,
                        input logic [3:0] fr, input logic rr, input logic [15:0] ra,
                        input logic frr);
      swrst               = sw;
      alloc_valid         = av;
      free_valid          = fv;
      free_is_root        = fr;
      tree_mgt_req_ready  = rr;
      tree_mgt_req_addr   = ra;
      tree_mgt_free_ready = frr;
   endtask

   initial begin
      int          p0, p1;
      logic [15:0] a1;
      bit          seen;

      areset    = 1'b1;
      drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0);
      free_addr = {16'h00D3, 16'h0010, 16'h00B1, 16'h00A0};
      #12;
      check("reset_state", 64'(outs()), 64'h0);
      @(negedge aclk);
      areset = 1'b0;

      // fairness: all four held, manager hands out 0..3 in order
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h0,16'h0000,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h0,16'h0000,1'b1,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0001,1'b0, 4'h1,16'h0000,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0001,1'b0, 4'h0,16'h0000,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0001,1'b0, 4'h0,16'h0000,1'b1,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0002,1'b0, 4'h2,16'h0001,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0002,1'b0, 4'h0,16'h0001,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0002,1'b0, 4'h0,16'h0001,1'b1,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0003,1'b0, 4'h4,16'h0002,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0003,1'b0, 4'h0,16'h0002,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0003,1'b0, 4'h0,16'h0002,1'b1,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'hF,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h8,16'h0003,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      // single alloc from engine 0 after wrap: ready two cycles after valid, addr 0x0005
      tbl.push_back(mk(1'b0,4'h1,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0003,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'h1,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0003,1'b1,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'h1,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h1,16'h0005,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0005,1'b0,4'h0,1'b0,16'h0000,1'b0,1'b0,1'b0));
      // free from engine 2, manager stalls three cycles
      tbl.push_back(mk(1'b0,4'h0,4'h4,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0005,1'b0,4'h4,1'b0,16'h0000,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0005,1'b0,4'h0,1'b1,16'h0010,1'b0,1'b0,1'b1));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0005,1'b0,4'h0,1'b1,16'h0010,1'b0,1'b0,1'b1));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0005,1'b0, 4'h0,16'h0005,1'b0,4'h0,1'b1,16'h0010,1'b0,1'b0,1'b1));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0005,1'b1, 4'h0,16'h0005,1'b0,4'h0,1'b1,16'h0010,1'b0,1'b0,1'b1));
      // concurrent alloc and non-root frees, back-to-back frees every two cycles
      tbl.push_back(mk(1'b0,4'h8,4'h1,4'h0,1'b1,16'h0042,1'b1, 4'h0,16'h0005,1'b0,4'h1,1'b0,16'h0010,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'h8,4'h1,4'h0,1'b1,16'h0042,1'b1, 4'h0,16'h0005,1'b1,4'h0,1'b1,16'h00A0,1'b0,1'b1,1'b1));
      tbl.push_back(mk(1'b0,4'h8,4'h1,4'h0,1'b1,16'h0042,1'b1, 4'h8,16'h0042,1'b0,4'h1,1'b0,16'h00A0,1'b0,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0042,1'b1, 4'h0,16'h0042,1'b0,4'h0,1'b1,16'h00A0,1'b0,1'b0,1'b1));
      // root free from engine 1 with alloc from engine 3: alloc held off until root free completes
      tbl.push_back(mk(1'b0,4'h8,4'h2,4'h2,1'b1,16'h0000,1'b0, 4'h0,16'h0042,1'b0,4'h2,1'b0,16'h00A0,1'b0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,4'h8,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h0,16'h0042,1'b0,4'h0,1'b1,16'h00B1,1'b1,1'b1,1'b1));
      tbl.push_back(mk(1'b0,4'h8,4'h0,4'h0,1'b1,16'h0000,1'b1, 4'h0,16'h0042,1'b0,4'h0,1'b1,16'h00B1,1'b1,1'b1,1'b1));
      tbl.push_back(mk(1'b0,4'h8,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h0,16'h0042,1'b1,4'h0,1'b0,16'h00B1,1'b1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'h8,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h8,16'h0000,1'b0,4'h0,1'b0,16'h00B1,1'b1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,4'h0,4'h0,4'h0,1'b1,16'h0000,1'b0, 4'h0,16'h0000,1'b0,4'h0,1'b0,16'h00B1,1'b1,1'b0,1'b0));

      for (int n = 0; n < tbl.size(); n++) begin
         drive(tbl[n].sw, tbl[n].av, tbl[n].fv, tbl[n].fr, tbl[n].rr, tbl[n].ra, tbl[n].frr);
         #3;
         check($sformatf("vec%0d", n), 64'(outs()),
               64'({tbl[n].e_ar, tbl[n].e_aa, tbl[n].e_rv, tbl[n].e_fr, tbl[n].e_fv,
                    tbl[n].e_fa, tbl[n].e_rt, tbl[n].e_ab, tbl[n].e_fb}));
         @(negedge aclk);
      end

      // manager exhaustion: engines 0 and 1 waiting, no response for 20 cycles
      drive(1'b0, 4'h3, 4'h0, 4'h0, 1'b0, 16'h0077, 1'b0);
      #3;
      check("exh_idle", 64'({alloc_ready, tree_mgt_req_valid}), 64'h0);
      @(negedge aclk);
      for (int k = 0; k < 20; k++) begin
         #3;
         check($sformatf("exh_stall%0d", k), 64'({alloc_ready, tree_mgt_req_valid}), 64'h01);
         @(negedge aclk);
      end
      tree_mgt_req_ready = 1'b1;
      #3;
      check("exh_release_hs", 64'(tree_mgt_req_valid), 64'h1);
      @(negedge aclk);
      #3;
      check("exh_resp", 64'({alloc_ready, alloc_addr}), 64'({4'h1, 16'h0077}));
      @(negedge aclk);
      p0 = 0; p1 = 0; a1 = '0; seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, seen ? 4'h0 : 4'h2, 4'h0, 4'h0, 1'b1, 16'h0078, 1'b0);
         #3;
         if (alloc_ready[0]) p0++;
         if (alloc_ready[1]) begin
            p1++;
            a1   = alloc_addr;
            seen = 1'b1;
         end
         @(negedge aclk);
      end
      check("exh_no_dup", 64'(p0), 64'd0);
      check("exh_next_cnt", 64'(p1), 64'd1);
      check("exh_next_addr", 64'(a1), 64'h0078);

      // soft reset with ALLOC in ISSUE and FREE in FWD, both pointers non-zero
      drive(1'b0, 4'h4, 4'h4, 4'h0, 1'b0, 16'h0055, 1'b0);
      #3;
      @(negedge aclk);
      drive(1'b0, 4'h4, 4'h0, 4'h0, 1'b0, 16'h0055, 1'b0);
      #3;
      check("sw_pre_busy", 64'({tree_mgt_req_valid, tree_mgt_free_valid, alloc_busy, free_busy}), 64'hF);
      @(negedge aclk);
      drive(1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 16'h0055, 1'b1);
      #3;
      check("sw_cycle", 64'({tree_mgt_req_valid, tree_mgt_free_valid, alloc_ready, free_ready}), 64'h0);
      @(negedge aclk);
      drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
      #3;
      check("sw_after", 64'(outs()), 64'h0);
      @(negedge aclk);
      drive(1'b0, 4'hF, 4'hF, 4'h0, 1'b1, 16'h0099, 1'b0);
      #3;
      check("sw_free_ptr", 64'(free_ready), 64'h1);
      @(negedge aclk);
      #3;
      check("sw_issue", 64'(tree_mgt_req_valid), 64'h1);
      @(negedge aclk);
      #3;
      check("sw_alloc_ptr", 64'({alloc_ready, alloc_addr}), 64'({4'h1, 16'h0099}));
      @(negedge aclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
